// File: rtl/matrix_cmd_seq_pkg.sv
// matrix_seq_pkg: shared types and constants for the MatrixMath command
// sequencer. Holds the sequencer state enum, the fixed command codes, the
// element count and helpers that build per-element load/read codes.
package matrix_seq_pkg;

  typedef enum logic [3:0] {
    ST_CLEAR,
    ST_CLEAR_GAP,
    ST_LOAD_WAIT,
    ST_LOAD_CMD,
    ST_LOAD_GAP,
    ST_READ_CMD,
    ST_READ_OUT,
    ST_READ_GAP,
    ST_DONE,
    ST_DONE_GAP
  } seq_state_e;

  localparam logic [7:0] CMD_IDLE      = 8'hBB;
  localparam logic [7:0] CMD_CLEAR     = 8'hAA;
  localparam logic [7:0] CMD_DONE      = 8'hEE;
  localparam logic [7:0] CMD_RD_D_BASE = 8'hD0;
  localparam logic [7:0] CMD_RD_E_BASE = 8'hE0;

  localparam int NUM_ELEMS = 18;
  localparam int IDX_W     = 5;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_ELEMS - 1);

  // Element k lives at {row, col} with row 1..6 (A in 1..3, B in 4..6).
  function automatic logic [7:0] load_code(idx_t k);
    logic [3:0] row;
    logic [3:0] col;
    row = 4'(k / 5'd3) + 4'd1;
    col = 4'(k % 5'd3) + 4'd1;
    return {row, col};
  endfunction

  // Results 0..8 read with 0xD0+j, results 9..17 with 0xE0+(j-9).
  function automatic logic [7:0] read_code(idx_t j);
    if (j < 5'd9) return CMD_RD_D_BASE + {3'b000, j};
    else          return CMD_RD_E_BASE + {3'b000, j - 5'd9};
  endfunction

endpackage

// File: rtl/matrix_cmd_seq_if.sv
// matrix_cmd_seq_if: bundles the operand stream, the result stream and the
// MatrixMath core command bus.
//   s_valid/s_ready/s_data        operand byte stream into the sequencer
//   m_valid/m_ready/m_data/m_last result byte stream out of the sequencer
//   mm_data/mm_cmd                to core ui_in/uio_in
//   mm_result                     from core uo_out
// slave  = sequencer side, master = host/core side.
interface matrix_cmd_seq_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [7:0] mm_data;
  logic [7:0] mm_cmd;
  logic [7:0] mm_result;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (
    output s_valid, s_data, m_ready, mm_result,
    input  s_ready, mm_data, mm_cmd, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready, mm_result,
    output s_ready, mm_data, mm_cmd, m_valid, m_data, m_last
  );
endinterface

// File: rtl/matrix_cmd_seq_timer.sv
// seq_timer: loadable down-counter timing the hold, idle and read-wait
// intervals. Loading N-1 on entry to an interval makes done high in the
// interval's final cycle, so the owner leaves after exactly N cycles.
//   clk, rst_n  clock, async active-low reset
//   load        load load_val (takes priority over counting)
//   load_val    remaining cycles minus one
//   done        count has reached zero
module seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load)           cnt_q <= load_val;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/matrix_cmd_seq.sv
// matrix_cmd_seq: host-side sequencer for the MatrixMath core. Takes 18
// operand bytes (A00..A22, B00..B22), issues clear/load/idle codes on
// mm_cmd with the operand on mm_data, then reads the 18 results back via
// read codes and returns them as a stream with m_last on the final byte.
//   clk, rst_n   clock, async active-low reset
//   bus          matrix_cmd_seq_if.slave (operand, result and core buses)
//   busy         high in every state except LOAD_WAIT
// Build option: MATRIX_SEQ_AUTOCLEAR_EN defined -> each run ends with a
// clear (0xAA, 0xBB) before the next operand is accepted; undefined -> the
// sequencer returns straight to LOAD_WAIT and core registers persist.
// Every output is a register loaded from the next-state decode, so mm_cmd
// only changes on state transitions.
module matrix_cmd_seq
  import matrix_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int IDLE_CYCLES = 1,
  parameter int READ_WAIT   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  matrix_cmd_seq_if.slave        bus,
  output logic                   busy
);
  localparam int MAX_D = (HOLD_CYCLES > IDLE_CYCLES) ?
                         ((HOLD_CYCLES > READ_WAIT) ? HOLD_CYCLES : READ_WAIT) :
                         ((IDLE_CYCLES > READ_WAIT) ? IDLE_CYCLES : READ_WAIT);
  localparam int TW    = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  seq_state_e    state_q, state_d;
  idx_t          k_q, k_d, j_q, j_d;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;
  logic [7:0]    cmd_d;

  seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    unique case (state_q)
      // Reset leaves mm_cmd at idle; stay until the clear code has been
      // on the bus for one cycle.
      ST_CLEAR:     if (bus.mm_cmd == CMD_CLEAR) state_d = ST_CLEAR_GAP;
      ST_CLEAR_GAP: if (tmr_done) state_d = ST_LOAD_WAIT;
      ST_LOAD_WAIT: if (bus.s_valid && bus.s_ready) state_d = ST_LOAD_CMD;
      ST_LOAD_CMD:  if (tmr_done) state_d = ST_LOAD_GAP;
      ST_LOAD_GAP: begin
        if (tmr_done) begin
          if (k_q == LAST_IDX) begin
            k_d     = '0;
            state_d = ST_READ_CMD;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_LOAD_WAIT;
          end
        end
      end
      ST_READ_CMD:  if (tmr_done) state_d = ST_READ_OUT;
      ST_READ_OUT:  if (bus.m_valid && bus.m_ready) state_d = ST_READ_GAP;
      ST_READ_GAP: begin
        if (tmr_done) begin
          if (j_q == LAST_IDX) begin
            j_d     = '0;
            state_d = ST_DONE;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = ST_READ_CMD;
          end
        end
      end
      ST_DONE:      state_d = ST_DONE_GAP;
      ST_DONE_GAP: begin
        if (tmr_done) begin
`ifdef MATRIX_SEQ_AUTOCLEAR_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_LOAD_WAIT;
`endif
        end
      end
      default:      state_d = ST_CLEAR;
    endcase
  end

  // Arm the shared timer with the length of whichever interval is entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_LOAD_CMD: tmr_val = TW'(HOLD_CYCLES - 1);
      ST_READ_CMD: tmr_val = TW'(READ_WAIT - 1);
      default:     tmr_val = TW'(IDLE_CYCLES - 1);
    endcase
  end

  // Read code stays up through READ_OUT so the core keeps driving the
  // result while the consumer stalls.
  always_comb begin
    case (state_d)
      ST_CLEAR:    cmd_d = CMD_CLEAR;
      ST_LOAD_CMD: cmd_d = load_code(k_d);
      ST_READ_CMD,
      ST_READ_OUT: cmd_d = read_code(j_d);
      ST_DONE:     cmd_d = CMD_DONE;
      default:     cmd_d = CMD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      k_q         <= '0;
      j_q         <= '0;
      bus.mm_cmd  <= CMD_IDLE;
      bus.mm_data <= 8'h00;
      bus.s_ready <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= 8'h00;
      bus.m_last  <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      j_q         <= j_d;
      bus.mm_cmd  <= cmd_d;
      bus.s_ready <= (state_d == ST_LOAD_WAIT);
      bus.m_valid <= (state_d == ST_READ_OUT);
      bus.m_last  <= (state_d == ST_READ_OUT) && (j_d == LAST_IDX);
      busy        <= (state_d != ST_LOAD_WAIT);
      if (bus.s_valid && bus.s_ready)
        bus.mm_data <= bus.s_data;
      // Capture on the last read-wait edge; held for the whole READ_OUT.
      if (state_q == ST_READ_CMD && state_d == ST_READ_OUT)
        bus.m_data <= bus.mm_result;
    end
  end
endmodule

// File: tb/tb_matrix_cmd_seq.sv
// Directed bench for matrix_cmd_seq with default parameters. A small core
// model answers read code j with 0x80+j.
module tb_matrix_cmd_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] op [18];
  logic [7:0] ld [18];
  logic [7:0] rd [18];

  matrix_cmd_seq_if bus();

  matrix_cmd_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.mm_result = 8'h00;
    if (bus.mm_cmd >= 8'hD0 && bus.mm_cmd <= 8'hD8)
      bus.mm_result = 8'h80 + (bus.mm_cmd - 8'hD0);
    else if (bus.mm_cmd >= 8'hE0 && bus.mm_cmd <= 8'hE8)
      bus.mm_result = 8'h89 + (bus.mm_cmd - 8'hE0);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge where LOAD_WAIT is expected; s_valid stays high.
  task automatic load_all();
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      chk("ld_ready", 8'(bus.s_ready), 8'd1);
      chk("ld_busy",  8'(busy),        8'd0);
      chk("ld_idle",  bus.mm_cmd,      8'hBB);
      bus.s_valid = 1'b1;
      bus.s_data  = op[k];
      @(negedge clk);
      chk("ld_code",  bus.mm_cmd,      ld[k]);
      chk("ld_data",  bus.mm_data,     op[k]);
      chk("ld_rdy0",  8'(bus.s_ready), 8'd0);
      @(negedge clk);
      chk("ld_gap",   bus.mm_cmd,      8'hBB);
    end
    bus.s_data = 8'h5A;
  endtask

  task automatic do_read(input int j, input bit stall);
    @(negedge clk);
    chk("rd_code1", bus.mm_cmd,      rd[j]);
    chk("rd_vld1",  8'(bus.m_valid), 8'd0);
    if (stall) bus.m_ready = 1'b0;
    @(negedge clk);
    chk("rd_code2", bus.mm_cmd,      rd[j]);
    chk("rd_vld2",  8'(bus.m_valid), 8'd0);
    chk("rd_mmdat", bus.mm_data,     8'h00);
    chk("rd_srdy",  8'(bus.s_ready), 8'd0);
    @(negedge clk);
    chk("rd_vld",   8'(bus.m_valid), 8'd1);
    chk("rd_data",  bus.m_data,      8'(8'h80 + j));
    chk("rd_last",  8'(bus.m_last),  8'(j == 17));
    chk("rd_code3", bus.mm_cmd,      rd[j]);
    if (stall) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk("st_vld",  8'(bus.m_valid), 8'd1);
        chk("st_data", bus.m_data,      8'(8'h80 + j));
        chk("st_code", bus.mm_cmd,      rd[j]);
      end
      bus.m_ready = 1'b1;
    end
    @(negedge clk);
    chk("rd_gap",   bus.mm_cmd,      8'hBB);
    chk("rd_vld0",  8'(bus.m_valid), 8'd0);
    chk("rd_last0", 8'(bus.m_last),  8'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd"},   bus.mm_cmd,      8'hBB);
    chk({tag, "_mmdat"}, bus.mm_data,     8'h00);
    chk({tag, "_srdy"},  8'(bus.s_ready), 8'd0);
    chk({tag, "_mvld"},  8'(bus.m_valid), 8'd0);
    chk({tag, "_mdat"},  bus.m_data,      8'h00);
    chk({tag, "_last"},  8'(bus.m_last),  8'd0);
    chk({tag, "_busy"},  8'(busy),        8'd1);
  endtask

  initial begin
    int idx;
    op = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hFF,
           8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10, 8'h00};
    idx = 0;
    for (int r = 1; r <= 6; r++)
      for (int c = 1; c <= 3; c++) begin
        ld[idx] = 8'(r * 16 + c);
        idx++;
      end
    for (int i = 0; i < 9; i++) begin
      rd[i]     = 8'hD0 + 8'(i);
      rd[i + 9] = 8'hE0 + 8'(i);
    end

    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.m_ready = 1'b1;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");

    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_code",  bus.mm_cmd,      8'hAA);
    chk("clr_busy",  8'(busy),        8'd1);
    @(negedge clk);
    chk("clr_gap",   bus.mm_cmd,      8'hBB);
    chk("clr_srdy",  8'(bus.s_ready), 8'd0);
    @(negedge clk);

    // Run 1: full load, full readback with a stall on j=4.
    load_all();
    for (int j = 0; j < 18; j++) do_read(j, j == 4);
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("done_code", bus.mm_cmd,      8'hEE);
    chk("done_srdy", 8'(bus.s_ready), 8'd0);
    @(negedge clk);
    chk("done_gap",  bus.mm_cmd,      8'hBB);
`ifdef MATRIX_SEQ_AUTOCLEAR_EN
    @(negedge clk);
    chk("aclr_code", bus.mm_cmd,      8'hAA);
    chk("aclr_srdy", 8'(bus.s_ready), 8'd0);
    @(negedge clk);
    chk("aclr_gap",  bus.mm_cmd,      8'hBB);
    chk("aclr_srd0", 8'(bus.s_ready), 8'd0);
`endif
    @(negedge clk);

    // Run 2: reset lands while result 7 is being presented.
    load_all();
    for (int j = 0; j < 7; j++) do_read(j, 1'b0);
    @(negedge clk);
    chk("r7_code", bus.mm_cmd, 8'hD7);
    bus.m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("r7_vld",  8'(bus.m_valid), 8'd1);
    chk("r7_data", bus.m_data,      8'h87);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mrst");
    @(negedge clk);
    chk_reset_vals("mrst_hold");
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk);
    chk("re_clr",  bus.mm_cmd,      8'hAA);
    @(negedge clk);
    chk("re_gap",  bus.mm_cmd,      8'hBB);
    @(negedge clk);
    chk("re_srdy", 8'(bus.s_ready), 8'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h3C;
    @(negedge clk);
    chk("re_code", bus.mm_cmd,      8'h11);
    chk("re_data", bus.mm_data,     8'h3C);
    bus.s_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
